// File: rtl/core_fsm_ctrl_pkg.sv
// Shared definitions for the keypad / SPI-display controller family.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package core_fsm_ctrl_pkg;

  // Defaults for the interface codes shared with keyin_counter and display
  localparam int         VALUE_W_DEF   = 16;
  localparam logic [2:0] KEY_ENTER_DEF = 3'd5;
  localparam logic [5:0] DISP_IDLE_DEF = 6'h00;
  localparam logic [5:0] DISP_DONE_DEF = 6'h3F;

  // Controller states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ENTRY = 3'd1,
    CHECK = 3'd2,
    LOAD  = 3'd3,
    WAIT  = 3'd4,
    RUN   = 3'd5,
    DONE  = 3'd6,
    CLEAR = 3'd7
  } state_t;

  // Commands driven to keyin_counter
  typedef enum logic [1:0] {
    OP_IDLE   = 2'b00,
    OP_ACCEPT = 2'b01,
    OP_HOLD   = 2'b10,
    OP_RSVD   = 2'b11
  } core_op_t;

  // Control outputs bundled so they can be decoded and registered together
  typedef struct packed {
    logic     off;
    core_op_t op;
    logic     set;
    logic     start;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_RESET = '{off: 1'b1, op: OP_IDLE, set: 1'b0, start: 1'b0};

  // A nibble is a legal BCD digit when it is 0..9
  function automatic logic nibble_is_bcd(input logic [3:0] nib);
    return (nib <= 4'd9);
  endfunction

endpackage

// File: rtl/core_fsm_ctrl_bcd_check.sv
// Flags whether every 4-bit digit of the value is a legal BCD digit (0..9).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input.
module core_fsm_ctrl_bcd_check
  import core_fsm_ctrl_pkg::*;
#(
  parameter int VALUE_W = VALUE_W_DEF
) (
  input  logic [VALUE_W-1:0] value,
  output logic               valid
);

  localparam int NIBBLES = VALUE_W / 4;

  // Any digit above 9 makes the whole value invalid
  always_comb begin
    valid = 1'b1;
    for (int i = 0; i < NIBBLES; i++) begin
      if (!nibble_is_bcd(value[i*4 +: 4])) begin
        valid = 1'b0;
      end
    end
  end

endmodule

// File: rtl/core_fsm_ctrl.sv
// Sequences value entry, BCD validation, display load (one-cycle set) and display run (start level).
// Latency: registered Moore outputs; a sampled condition shows on the outputs one cycle later.
// Backpressure: waits indefinitely in ENTRY for keyin and in WAIT for the display to go idle.
module core_fsm_ctrl
  import core_fsm_ctrl_pkg::*;
#(
  parameter int         VALUE_W   = VALUE_W_DEF,
  parameter logic [2:0] KEY_ENTER = KEY_ENTER_DEF,
  parameter logic [5:0] DISP_IDLE = DISP_IDLE_DEF,
  parameter logic [5:0] DISP_DONE = DISP_DONE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pressed,
  input  logic [2:0]         keyin_state,
  input  logic [VALUE_W-1:0] key_in_value,
  input  logic [1:0]         key_in_mode,
  input  logic [5:0]         display_state,
  output logic               off,
  output logic [1:0]         core_op,
  output logic [1:0]         core_mode,
  output logic               set,
  output logic               start,
  output logic [VALUE_W-1:0] core_value_out
);

  state_t             state;
  state_t             state_nxt;
  ctrl_out_t          out_q;
  ctrl_out_t          out_nxt;
  logic               pressed_q;
  logic               press_edge;
  logic               value_ok;
  logic               latch_en;
  logic [VALUE_W-1:0] value_q;
  logic [1:0]         mode_q;

  // A held key produces a single edge because pressed_q follows pressed every cycle
  assign press_edge = pressed & ~pressed_q;

  // Value and mode are captured only when a valid entry leaves CHECK
  assign latch_en = (state == CHECK) && value_ok;

  core_fsm_ctrl_bcd_check #(
    .VALUE_W (VALUE_W)
  ) u_bcd_check (
    .value (key_in_value),
    .valid (value_ok)
  );

  // Next-state selection; RUN gives display completion priority over a user abort
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = ENTRY;
      ENTRY:   if (keyin_state == KEY_ENTER) state_nxt = CHECK;
      CHECK:   state_nxt = value_ok ? LOAD : CLEAR;
      LOAD:    state_nxt = WAIT;
      WAIT:    if (display_state == DISP_IDLE) state_nxt = RUN;
      RUN: begin
        if (display_state == DISP_DONE) begin
          state_nxt = DONE;
        end else if (press_edge) begin
          state_nxt = CLEAR;
        end
      end
      DONE:    if (press_edge) state_nxt = CLEAR;
      CLEAR:   state_nxt = ENTRY;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered copy lines up with the state register
  always_comb begin
    out_nxt = '{off: 1'b0, op: OP_HOLD, set: 1'b0, start: 1'b0};
    case (state_nxt)
      IDLE: begin
        out_nxt.off = 1'b1;
        out_nxt.op  = OP_IDLE;
      end
      ENTRY:   out_nxt.op    = OP_ACCEPT;
      CHECK:   out_nxt.op    = OP_HOLD;
      LOAD:    out_nxt.set   = 1'b1;
      WAIT:    out_nxt.op    = OP_HOLD;
      RUN:     out_nxt.start = 1'b1;
      DONE:    out_nxt.op    = OP_HOLD;
      CLEAR: begin
        out_nxt.off = 1'b1;
        out_nxt.op  = OP_IDLE;
      end
      default: begin
        out_nxt.off = 1'b1;
        out_nxt.op  = OP_IDLE;
      end
    endcase
  end

  // State, output, edge-detect and latch registers; reset overrides any operation in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_q     <= CTRL_RESET;
      pressed_q <= 1'b0;
      value_q   <= '0;
      mode_q    <= '0;
    end else begin
      state     <= state_nxt;
      out_q     <= out_nxt;
      pressed_q <= pressed;
      if (latch_en) begin
        value_q <= key_in_value;
        mode_q  <= key_in_mode;
      end
    end
  end

  assign off            = out_q.off;
  assign core_op        = out_q.op;
  assign set            = out_q.set;
  assign start          = out_q.start;
  assign core_value_out = value_q;
  assign core_mode      = mode_q;

endmodule

// File: tb/tb_core_fsm_ctrl.sv
// Self-checking bench for core_fsm_ctrl: vector table through a scoreboard plus corner sequences.
// Latency: n/a.
// Backpressure: n/a.
module tb_core_fsm_ctrl;
  import core_fsm_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pressed = 1'b0;
  logic [2:0]  keyin_state = 3'd0;
  logic [15:0] key_in_value = 16'h0;
  logic [1:0]  key_in_mode = 2'b00;
  logic [5:0]  display_state = 6'h00;
  logic        off;
  logic [1:0]  core_op;
  logic [1:0]  core_mode;
  logic        set;
  logic        start;
  logic [15:0] core_value_out;

  core_fsm_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .pressed        (pressed),
    .keyin_state    (keyin_state),
    .key_in_value   (key_in_value),
    .key_in_mode    (key_in_mode),
    .display_state  (display_state),
    .off            (off),
    .core_op        (core_op),
    .core_mode      (core_mode),
    .set            (set),
    .start          (start),
    .core_value_out (core_value_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic [1:0]  mode;
    logic        valid;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [15:0] value;
    logic [1:0]  mode;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  vec_t        vecs[8];
  logic        armed = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          inv_viol = 0;
  logic [15:0] model_value = 16'h0;
  logic [1:0]  model_mode = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Scoreboard consumer: first set or off pulse after a vector is the DUT's verdict on it
  always @(negedge clk) begin
    if (armed && !rst && (set || off)) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_empty: got output event, expected none queued");
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_set",   32'(set),            32'(mon_e.valid));
        check("sb_off",   32'(off),            32'(!mon_e.valid));
        check("sb_value", 32'(core_value_out), 32'(mon_e.value));
        check("sb_mode",  32'(core_mode),      32'(mon_e.mode));
      end
      armed = 1'b0;
    end
  end

  // Invariants that must hold on every cycle
  always @(negedge clk) begin
    if (set && off) inv_viol++;
    if (start && (set || off)) inv_viol++;
  end

  // Presents one entry from ENTRY and waits for the scoreboard to see the verdict; ends one cycle later
  task automatic enter_value(input vec_t v);
    exp_t e;
    e.valid = v.valid;
    if (v.valid) begin
      model_value = v.value;
      model_mode  = v.mode;
    end
    e.value = model_value;
    e.mode  = model_mode;
    key_in_value = v.value;
    key_in_mode  = v.mode;
    keyin_state  = KEY_ENTER_DEF;
    sb_q.push_back(e);
    armed = 1'b1;
    @(negedge clk);
    keyin_state = 3'd0;
    for (int i = 0; i < 10 && armed; i++) begin
      @(negedge clk);
      #1;
    end
    if (armed) begin
      n_cmp++;
      n_bad++;
      $display("FAIL sb_timeout: got no set/off pulse, expected one within 10 cycles");
      sb_q.delete();
      armed = 1'b0;
    end
    @(negedge clk);
    check("pulse_one_cycle_set", 32'(set), 32'd0);
    check("pulse_one_cycle_off", 32'(off), 32'd0);
    if (!v.valid) begin
      check("reject_back_entry_op", 32'(core_op),        32'd1);
      check("reject_value_kept",    32'(core_value_out), 32'(model_value));
    end
  endtask

  task automatic wait_start(input string name);
    for (int i = 0; i < 6 && !start; i++) @(negedge clk);
    check(name, 32'(start), 32'd1);
  endtask

  // From RUN: display finishes, then a press clears back to ENTRY
  task automatic finish_run();
    check("run_op_hold", 32'(core_op), 32'd2);
    display_state = DISP_DONE_DEF;
    @(negedge clk);
    check("done_start_low", 32'(start),          32'd0);
    check("done_value",     32'(core_value_out), 32'(model_value));
    check("done_mode",      32'(core_mode),      32'(model_mode));
    pressed = 1'b1;
    @(negedge clk);
    pressed = 1'b0;
    check("done_clear_off", 32'(off),     32'd1);
    check("done_clear_op",  32'(core_op), 32'd0);
    @(negedge clk);
    check("done_entry_off", 32'(off),     32'd0);
    check("done_entry_op",  32'(core_op), 32'd1);
    display_state = DISP_IDLE_DEF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   offs;
    int   late_start;
    vec_t v;

    vecs[0] = '{value: 16'h0963, mode: 2'b01, valid: 1'b1};
    vecs[1] = '{value: 16'h0A12, mode: 2'b10, valid: 1'b0};
    vecs[2] = '{value: 16'h9999, mode: 2'b11, valid: 1'b1};
    vecs[3] = '{value: 16'h0000, mode: 2'b00, valid: 1'b1};
    vecs[4] = '{value: 16'hF000, mode: 2'b01, valid: 1'b0};
    vecs[5] = '{value: 16'h123A, mode: 2'b10, valid: 1'b0};
    vecs[6] = '{value: 16'h5080, mode: 2'b10, valid: 1'b1};
    vecs[7] = '{value: 16'h00B0, mode: 2'b11, valid: 1'b0};

    // Reset held three cycles
    repeat (3) @(negedge clk);
    check("rst_off",   32'(off),            32'd1);
    check("rst_op",    32'(core_op),        32'd0);
    check("rst_set",   32'(set),            32'd0);
    check("rst_start", 32'(start),          32'd0);
    check("rst_value", 32'(core_value_out), 32'd0);
    check("rst_mode",  32'(core_mode),      32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("entry_off", 32'(off),     32'd0);
    check("entry_op",  32'(core_op), 32'd1);

    // Vector table through the scoreboard
    for (int k = 0; k < 8; k++) begin
      enter_value(vecs[k]);
      if (vecs[k].valid) begin
        wait_start("run_start");
        finish_run();
      end
    end

    // Held key in RUN aborts exactly once
    v = '{value: 16'h1234, mode: 2'b10, valid: 1'b1};
    enter_value(v);
    wait_start("hold_run_start");
    offs = 0;
    late_start = 0;
    pressed = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (off) offs++;
      if (start && offs > 0) late_start++;
    end
    pressed = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (off) offs++;
    end
    check("hold_one_off",     32'(offs),       32'd1);
    check("hold_no_restart",  32'(late_start), 32'd0);
    check("hold_start_low",   32'(start),      32'd0);
    check("hold_entry_op",    32'(core_op),    32'd1);
    check("hold_value_kept",  32'(core_value_out), 32'h1234);

    // Reset in the middle of RUN
    v = '{value: 16'h0420, mode: 2'b11, valid: 1'b1};
    enter_value(v);
    wait_start("rst_run_start");
    rst = 1'b1;
    @(negedge clk);
    model_value = 16'h0;
    model_mode  = 2'b00;
    check("midrst_off",   32'(off),            32'd1);
    check("midrst_op",    32'(core_op),        32'd0);
    check("midrst_set",   32'(set),            32'd0);
    check("midrst_start", 32'(start),          32'd0);
    check("midrst_value", 32'(core_value_out), 32'd0);
    check("midrst_mode",  32'(core_mode),      32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_entry_off", 32'(off),     32'd0);
    check("midrst_entry_op",  32'(core_op), 32'd1);

    check("invariants", 32'(inv_viol), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
